// File: rtl/hrfp_normalize_round_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : hrfp_normalize_round_pipe                                     |
// | Purpose  : Two-stage HRFP normalise + round-to-nearest-even with a       |
// |            valid/ready pipeline and exponent overflow/underflow checks.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module hrfp_normalize_round_pipe #(
  parameter int NDIG       = 8,
  parameter int OUT_DIGITS = 6,
  parameter int DIGIT_W    = 4,
  parameter int EXP_W      = 7
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic                             in_sign,
  input  logic [EXP_W-1:0]                 in_exp,
  input  logic                             in_special,
  input  logic                             in_nan,
  input  logic [NDIG*DIGIT_W:0]            in_mant,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic                             out_sign,
  output logic [EXP_W-1:0]                 out_exp,
  output logic                             out_special,
  output logic                             out_nan,
  output logic [OUT_DIGITS*DIGIT_W-1:0]    out_mant,
  output logic                             out_underflow
);

  localparam int FW  = NDIG * DIGIT_W;
  localparam int MW  = FW + 1;
  localparam int OW  = OUT_DIGITS * DIGIT_W;
  localparam int LZW = $clog2(NDIG + 1);
  localparam int XW  = EXP_W + 2;

  // Bits strictly below the round bit; they feed the sticky OR.
  localparam logic [FW-1:0] LOW_MASK   = {FW{1'b1}} >> (OW + 1);
  localparam logic [OW-1:0] CARRY_MANT = {1'b1, {(OW-1){1'b0}}} >> (DIGIT_W - 1);
  localparam logic [EXP_W-1:0] EXP_MAX = {EXP_W{1'b1}};

  // Handshake
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_adv;
  logic in_fire;

  assign s2_adv   = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s2_adv;
  assign in_fire  = in_valid && in_ready;

  // Stage 1 combinational: leading-zero digit count and shift
  logic [LZW-1:0] lz;
  logic           lz_found;
  logic [FW-1:0]  norm_frac;
  logic           norm_sticky;
  logic [XW-1:0]  norm_exp;

  always_comb begin
    lz       = LZW'(NDIG);
    lz_found = 1'b0;
    for (int i = 0; i < NDIG; i++) begin
      if (!lz_found && (in_mant[(NDIG-1-i)*DIGIT_W +: DIGIT_W] != '0)) begin
        lz       = LZW'(i);
        lz_found = 1'b1;
      end
    end
  end

  always_comb begin
    norm_frac   = in_mant[FW-1:0] << (lz * DIGIT_W);
    norm_sticky = 1'b0;
    norm_exp    = {2'b00, in_exp} - XW'(lz);
    if (in_mant[MW-1]) begin
      norm_frac   = FW'(in_mant >> DIGIT_W);
      norm_sticky = |in_mant[DIGIT_W-1:0];
      norm_exp    = {2'b00, in_exp} + XW'(1);
    end
    if (in_special) begin
      norm_exp = {2'b00, in_exp};
    end
  end

  // Stage 1 registers
  logic          s1_sign_q,    s1_sign_d;
  logic [XW-1:0] s1_exp_q,     s1_exp_d;
  logic          s1_special_q, s1_special_d;
  logic          s1_nan_q,     s1_nan_d;
  logic          s1_zero_q,    s1_zero_d;
  logic [FW-1:0] s1_frac_q,    s1_frac_d;
  logic          s1_sticky_q,  s1_sticky_d;

  always_comb begin
    s1_valid_d   = s1_valid_q;
    s1_sign_d    = s1_sign_q;
    s1_exp_d     = s1_exp_q;
    s1_special_d = s1_special_q;
    s1_nan_d     = s1_nan_q;
    s1_zero_d    = s1_zero_q;
    s1_frac_d    = s1_frac_q;
    s1_sticky_d  = s1_sticky_q;
    if (in_fire) begin
      s1_valid_d   = 1'b1;
      s1_sign_d    = in_sign;
      s1_exp_d     = norm_exp;
      s1_special_d = in_special;
      s1_nan_d     = in_special && in_nan;
      s1_zero_d    = (in_mant == '0);
      s1_frac_d    = norm_frac;
      s1_sticky_d  = norm_sticky;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q   <= 1'b0;
      s1_sign_q    <= 1'b0;
      s1_exp_q     <= '0;
      s1_special_q <= 1'b0;
      s1_nan_q     <= 1'b0;
      s1_zero_q    <= 1'b0;
      s1_frac_q    <= '0;
      s1_sticky_q  <= 1'b0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_sign_q    <= s1_sign_d;
      s1_exp_q     <= s1_exp_d;
      s1_special_q <= s1_special_d;
      s1_nan_q     <= s1_nan_d;
      s1_zero_q    <= s1_zero_d;
      s1_frac_q    <= s1_frac_d;
      s1_sticky_q  <= s1_sticky_d;
    end
  end

  // Stage 2 combinational: RNE rounding and final exponent checks
  logic [OW-1:0]    kept;
  logic             rnd_bit;
  logic             stk_bit;
  logic             rnd_inc;
  logic [OW:0]      rnd_sum;
  logic [OW-1:0]    rnd_mant;
  logic [XW-1:0]    rnd_exp;
  logic             res_sign;
  logic [EXP_W-1:0] res_exp;
  logic             res_special;
  logic             res_nan;
  logic [OW-1:0]    res_mant;
  logic             res_uf;

  always_comb begin
    kept    = s1_frac_q[FW-1 -: OW];
    rnd_bit = s1_frac_q[FW-OW-1];
    stk_bit = (|(s1_frac_q & LOW_MASK)) || s1_sticky_q;
    rnd_inc = rnd_bit && (stk_bit || kept[0]);
    rnd_sum = {1'b0, kept} + {{OW{1'b0}}, rnd_inc};
    if (rnd_sum[OW]) begin
      rnd_mant = CARRY_MANT;
      rnd_exp  = s1_exp_q + XW'(1);
    end else begin
      rnd_mant = rnd_sum[OW-1:0];
      rnd_exp  = s1_exp_q;
    end
  end

  // Priority: special pass-through, zero, underflow, overflow, normal.
  always_comb begin
    res_sign    = s1_sign_q;
    res_exp     = rnd_exp[EXP_W-1:0];
    res_special = 1'b0;
    res_nan     = 1'b0;
    res_mant    = rnd_mant;
    res_uf      = 1'b0;
    if (s1_special_q) begin
      res_exp     = s1_exp_q[EXP_W-1:0];
      res_special = 1'b1;
      res_nan     = s1_nan_q;
      res_mant    = '0;
    end else if (s1_zero_q) begin
      res_exp  = '0;
      res_mant = '0;
    end else if (rnd_exp[XW-1]) begin
      res_exp  = '0;
      res_mant = '0;
      res_uf   = 1'b1;
    end else if (rnd_exp[EXP_W]) begin
      res_exp     = EXP_MAX;
      res_special = 1'b1;
      res_mant    = '0;
    end
  end

  // Stage 2 registers drive the outputs directly
  logic             s2_sign_q,    s2_sign_d;
  logic [EXP_W-1:0] s2_exp_q,     s2_exp_d;
  logic             s2_special_q, s2_special_d;
  logic             s2_nan_q,     s2_nan_d;
  logic [OW-1:0]    s2_mant_q,    s2_mant_d;
  logic             s2_uf_q,      s2_uf_d;

  always_comb begin
    s2_valid_d   = s2_valid_q;
    s2_sign_d    = s2_sign_q;
    s2_exp_d     = s2_exp_q;
    s2_special_d = s2_special_q;
    s2_nan_d     = s2_nan_q;
    s2_mant_d    = s2_mant_q;
    s2_uf_d      = s2_uf_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_sign_d    = res_sign;
        s2_exp_d     = res_exp;
        s2_special_d = res_special;
        s2_nan_d     = res_nan;
        s2_mant_d    = res_mant;
        s2_uf_d      = res_uf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q   <= 1'b0;
      s2_sign_q    <= 1'b0;
      s2_exp_q     <= '0;
      s2_special_q <= 1'b0;
      s2_nan_q     <= 1'b0;
      s2_mant_q    <= '0;
      s2_uf_q      <= 1'b0;
    end else begin
      s2_valid_q   <= s2_valid_d;
      s2_sign_q    <= s2_sign_d;
      s2_exp_q     <= s2_exp_d;
      s2_special_q <= s2_special_d;
      s2_nan_q     <= s2_nan_d;
      s2_mant_q    <= s2_mant_d;
      s2_uf_q      <= s2_uf_d;
    end
  end

  assign out_valid     = s2_valid_q;
  assign out_sign      = s2_sign_q;
  assign out_exp       = s2_exp_q;
  assign out_special   = s2_special_q;
  assign out_nan       = s2_nan_q;
  assign out_mant      = s2_mant_q;
  assign out_underflow = s2_uf_q;

endmodule
`default_nettype wire

// File: tb/tb_hrfp_normalize_round_pipe.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_hrfp_normalize_round_pipe                                  |
// | Purpose  : Scoreboard bench for the HRFP normalise/round pipeline.       |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_hrfp_normalize_round_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sign;
  logic [6:0]  in_exp;
  logic        in_special;
  logic        in_nan;
  logic [32:0] in_mant;
  logic        out_valid;
  logic        out_ready;
  logic        out_sign;
  logic [6:0]  out_exp;
  logic        out_special;
  logic        out_nan;
  logic [23:0] out_mant;
  logic        out_underflow;

  hrfp_normalize_round_pipe #(
    .NDIG(8), .OUT_DIGITS(6), .DIGIT_W(4), .EXP_W(7)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_special(in_special),
    .in_nan(in_nan), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_exp(out_exp), .out_special(out_special),
    .out_nan(out_nan), .out_mant(out_mant), .out_underflow(out_underflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        sign;
    logic [6:0]  exp;
    logic        special;
    logic        nan;
    logic [23:0] mant;
    logic        uf;
    logic [31:0] cyc;
    logic        chk_lat;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input logic s, input logic [6:0] e, input logic sp,
                              input logic n, input logic [23:0] m, input logic u);
    exp_t r;
    r.sign = s; r.exp = e; r.special = sp; r.nan = n; r.mant = m; r.uf = u;
    r.cyc = '0; r.chk_lat = 1'b0;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Inputs change at posedge+1; the beat is accepted if in_ready holds at negedge.
  task automatic send(input logic s, input logic [6:0] e, input logic sp, input logic n,
                      input logic [32:0] m, input exp_t ex, input bit lat);
    bit acc = 0;
    in_sign = s; in_exp = e; in_special = sp; in_nan = n; in_mant = m;
    in_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      if (in_ready) begin
        ex.cyc     = cyc;
        ex.chk_lat = lat;
        sb.push_back(ex);
        acc = 1;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_vec++; n_err++;
      $display("FAIL send_timeout: in_ready stuck 0 for mant %h", m);
    end
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); t++;
    end
    #1;
    if (sb.size() != 0) begin
      n_vec++; n_err++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb.size());
    end
  endtask

  // Monitor: compare presented beat with scoreboard head; pop on handshake.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_beat: got mant %h exp %h, expected no beat", out_mant, out_exp);
      end else begin
        exp_t e;
        e = sb[0];
        n_vec++;
        if ({out_sign, out_exp, out_special, out_nan, out_mant, out_underflow} !==
            {e.sign, e.exp, e.special, e.nan, e.mant, e.uf}) begin
          n_err++;
          $display("FAIL beat: got s=%0b e=%h sp=%0b n=%0b m=%h uf=%0b, expected s=%0b e=%h sp=%0b n=%0b m=%h uf=%0b",
                   out_sign, out_exp, out_special, out_nan, out_mant, out_underflow,
                   e.sign, e.exp, e.special, e.nan, e.mant, e.uf);
        end
        if (e.chk_lat && out_ready) begin
          n_vec++;
          if (cyc != e.cyc + 2) begin
            n_err++;
            $display("FAIL latency: got %0d cycles, expected 2", cyc - e.cyc);
          end
        end
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_sign = 0; in_exp = '0; in_special = 0; in_nan = 0; in_mant = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready",  64'(in_ready),  64'd1);
    chk("reset_data", 64'({out_sign, out_exp, out_special, out_nan, out_mant, out_underflow}), 64'd0);
    @(posedge clk); #1;

    // Directed vectors
    send(0, 7'h40, 0, 0, 33'h0_0012_3456, mk(0, 7'h3E, 0, 0, 24'h123456, 0), 1);
    send(1, 7'h40, 0, 0, 33'h1_2345_6780, mk(1, 7'h41, 0, 0, 24'h123456, 0), 0);
    send(0, 7'h40, 0, 0, 33'h0_FFFF_FF80, mk(0, 7'h41, 0, 0, 24'h100000, 0), 0);
    send(0, 7'h7F, 0, 0, 33'h1_0000_0000, mk(0, 7'h7F, 1, 0, 24'h000000, 0), 0);
    send(0, 7'h01, 0, 0, 33'h0_0001_0000, mk(0, 7'h00, 0, 0, 24'h000000, 1), 0);
    send(0, 7'h40, 0, 0, 33'h0_0000_0000, mk(0, 7'h00, 0, 0, 24'h000000, 0), 0);
    send(1, 7'h55, 1, 1, 33'h1_2345_6789, mk(1, 7'h55, 1, 1, 24'h000000, 0), 0);
    send(0, 7'h40, 0, 0, 33'h0_1234_5680, mk(0, 7'h40, 0, 0, 24'h123456, 0), 0);
    send(0, 7'h40, 0, 0, 33'h0_1234_5681, mk(0, 7'h40, 0, 0, 24'h123457, 0), 0);
    send(0, 7'h40, 0, 0, 33'h1_2345_6801, mk(0, 7'h41, 0, 0, 24'h123457, 0), 0);
    send(0, 7'h7F, 0, 0, 33'h0_FFFF_FF80, mk(0, 7'h7F, 1, 0, 24'h000000, 0), 0);
    send(0, 7'h03, 0, 0, 33'h0_0001_0000, mk(0, 7'h00, 0, 0, 24'h100000, 0), 0);
    send(0, 7'h7F, 1, 0, 33'h0_0000_0000, mk(0, 7'h7F, 1, 0, 24'h000000, 0), 0);
    drain();

    // Streaming with a 3-cycle downstream stall
    fork
      begin
        for (int i = 0; i < 10; i++)
          send(0, 7'(8'h30 + i), 0, 0, 33'(i + 1) << 24,
               mk(0, 7'(8'h30 + i - 1), 0, 0, 24'(i + 1) << 20, 0), 0);
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("stall_in_ready",  64'(in_ready),  64'd0);
        chk("stall_out_valid", 64'(out_valid), 64'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    out_ready = 1'b0;
    send(0, 7'h40, 0, 0, 33'h0_0012_3456, mk(0, 7'h3E, 0, 0, 24'h123456, 0), 0);
    send(0, 7'h40, 0, 0, 33'h0_1234_5681, mk(0, 7'h40, 0, 0, 24'h123457, 0), 0);
    rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_in_ready",  64'(in_ready),  64'd1);
    repeat (5) @(posedge clk);
    #1;
    send(1, 7'h40, 0, 0, 33'h1_2345_6780, mk(1, 7'h41, 0, 0, 24'h123456, 0), 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
